mipi_hs_serializer: RTL and testbench

// HS-mode transmit serializer for one D-PHY data lane; it is the TX-side counterpart of the lane deserializer.
// - Accepts bytes over a valid/ready handshake.
// - Wraps each burst in the HS-ZERO preamble, the SoT sync byte and the HS-TRAIL.
// - Shifts everything out LSB first, one bit per clock, to the HS line driver.
// - A lane deserializer fed by DTXHSP must lock SYNC and recover every byte unchanged.

---
 rtl/mipi_hs_serializer.sv | 140 ++++++++++++++
 tb/tb_mipi_hs_serializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_hs_serializer.sv
// HS-mode transmit serializer for one D-PHY data lane: HS-ZERO, SoT sync byte,
// LSB-first payload bytes and HS-TRAIL, one bit per TxDDRClkHS rising edge.
module mipi_hs_serializer #(
  parameter int unsigned ZERO_CYC  = 16,
  parameter int unsigned TRAIL_CYC = 16,
  parameter logic [7:0]  SYNC_WORD = 8'hB8
) (
  input  logic       TxDDRClkHS,
  input  logic       HS_SER_RST,
  input  logic       TX_REQ,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       DTXHSP,
  output logic       HS_TX_EN,
  output logic       HS_BYTE_CLKD,
  output logic       BURST_DONE,
  output logic [2:0] state_dbg
);

  // Handshake: a byte moves on a rising edge where TX_READY (registered, shown
  // during bit slot 7 of the outgoing byte) and TX_VALID are both 1; TX_VALID
  // without TX_READY is ignored and the byte stays with the producer.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ZERO  = 3'd1,
    S_SYNC  = 3'd2,
    S_DATA  = 3'd3,
    S_TRAIL = 3'd4
  } state_t;

  localparam logic [7:0] ZERO_LAST  = 8'(ZERO_CYC - 1);
  localparam logic [7:0] TRAIL_N    = 8'(TRAIL_CYC);
  localparam logic [7:0] TRAIL_LAST = 8'(TRAIL_CYC - 1);

  // State names the slot that the next rising edge launches onto the line.
  state_t     state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic       ready_d, dtx_d, en_d, bclk_d, done_d;

  assign state_dbg = state_q;

  always_ff @(posedge TxDDRClkHS or posedge HS_SER_RST) begin
    if (HS_SER_RST) begin
      state_q      <= S_IDLE;
      phase_q      <= 8'd0;
      bit_q        <= 3'd0;
      shreg_q      <= 8'd0;
      TX_READY     <= 1'b0;
      DTXHSP       <= 1'b0;
      HS_TX_EN     <= 1'b0;
      HS_BYTE_CLKD <= 1'b0;
      BURST_DONE   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      TX_READY     <= ready_d;
      DTXHSP       <= dtx_d;
      HS_TX_EN     <= en_d;
      HS_BYTE_CLKD <= bclk_d;
      BURST_DONE   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ready_d = 1'b0;
    dtx_d   = 1'b0;
    en_d    = 1'b0;
    bclk_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (TX_REQ) begin
          state_d = S_ZERO;
          phase_d = 8'd0;
        end
      end
      S_ZERO: begin
        en_d = 1'b1;
        if (phase_q == ZERO_LAST) begin
          state_d = S_SYNC;
          phase_d = 8'd0;
          bit_d   = 3'd0;
          shreg_d = SYNC_WORD;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      S_SYNC, S_DATA: begin
        en_d = 1'b1;
        // DATA with bit index 0 is the byte boundary: launch a new byte or the trail.
        if (state_q == S_DATA && bit_q == 3'd0) begin
          if (TX_READY && TX_VALID) begin
            shreg_d = TX_DATA;
            dtx_d   = TX_DATA[0];
            bclk_d  = 1'b1;
            bit_d   = 3'd1;
          end else begin
            state_d = S_TRAIL;
            dtx_d   = ~shreg_q[7];
            phase_d = 8'd1;
            done_d  = (TRAIL_CYC == 1);
          end
        end else begin
          dtx_d   = shreg_q[bit_q];
          bclk_d  = ~bit_q[2];
          ready_d = (bit_q == 3'd7) && TX_REQ;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7)
            state_d = S_DATA;
        end
      end
      S_TRAIL: begin
        if (phase_q == TRAIL_N) begin
          // Going quiet; a request still held here starts the next burst.
          state_d = TX_REQ ? S_ZERO : S_IDLE;
          phase_d = 8'd0;
        end else begin
          en_d    = 1'b1;
          dtx_d   = ~shreg_q[7];
          done_d  = (phase_q == TRAIL_LAST);
          phase_d = phase_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mipi_hs_serializer.sv
// Bench for mipi_hs_serializer: table of bursts, random bursts, a loopback
// deserializer model and hand-written reset / re-request sequences.
module tb_mipi_hs_serializer;

  localparam int         ZC = 16;
  localparam int         TC = 16;
  localparam logic [7:0] SW = 8'hB8;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_req, tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, dtxhsp, hs_tx_en, hs_byte_clkd, burst_done;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  logic [7:0] payload [0:63];

  typedef struct {
    string       name;
    int          n;
    int          mode;      // 0: hold request per byte, 1: one-cycle request, 2: stall after bytes
    logic [23:0] bytes;
    int          exp_hs;
    logic        exp_trail;
  } vec_t;

  vec_t vecs [0:3];

  mipi_hs_serializer #(.ZERO_CYC(ZC), .TRAIL_CYC(TC), .SYNC_WORD(SW)) dut (
    .TxDDRClkHS  (clk),
    .HS_SER_RST  (rst),
    .TX_REQ      (tx_req),
    .TX_DATA     (tx_data),
    .TX_VALID    (tx_valid),
    .TX_READY    (tx_ready),
    .DTXHSP      (dtxhsp),
    .HS_TX_EN    (hs_tx_en),
    .HS_BYTE_CLKD(hs_byte_clkd),
    .BURST_DONE  (burst_done),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // reference: the line sequence of a burst, from the framing rules alone
  task automatic build_expected(input int n);
    logic [7:0] sw_v;
    logic       last;
    sw_v = SW;
    exp_q.delete();
    for (int i = 0; i < ZC; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(sw_v[i]);
    last = sw_v[7];
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(payload[b][i]);
      last = payload[b][7];
    end
    for (int i = 0; i < TC; i++) exp_q.push_back(~last);
  endtask

  // driver + monitor for one burst; inputs change and outputs are sampled on negedges
  task automatic run_burst(input string name, input int n, input int mode,
                           input int exp_hs, input logic exp_trail);
    int   idx = 0, hs = 0, cyc = 0, first_en = -1, done_at = -1, done_cnt = 0, en_cnt = 0;
    int   pos, bits_bad = 0, bclk_bad = 0, post_en = 0;
    logic pend = 1'b0, over = 1'b0, exp_bclk;
    build_expected(n);
    got_q.delete();
    tx_req   = 1'b1;
    tx_valid = (n > 0);
    tx_data  = payload[0];
    while (!over && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (hs_tx_en) begin
        if (first_en < 0) first_en = cyc;
        got_q.push_back(dtxhsp);
        pos = en_cnt;
        en_cnt++;
        exp_bclk = (pos >= ZC && pos < ZC + 8 * (n + 1)) ? (((pos - ZC) % 8) < 4) : 1'b0;
        if (hs_byte_clkd !== exp_bclk) bclk_bad++;
      end
      if (burst_done) begin
        done_cnt++;
        done_at = en_cnt;
      end
      if (first_en >= 0 && !hs_tx_en) over = 1'b1;
      if (pend) begin
        idx++;
        hs++;
      end
      if (mode == 1)      tx_req = 1'b0;
      else if (mode == 0) tx_req = (idx < n);
      else                tx_req = (done_cnt == 0);
      tx_valid = (idx < n) || (mode == 2 && en_cnt > ZC + 8 * (n + 1));
      tx_data  = (idx < 64) ? payload[idx] : 8'h00;
      pend     = tx_ready && tx_valid;
    end
    if (mode == 2) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (hs_tx_en) post_en++;
      end
      check({name, " no_restart"}, post_en, 0);
    end
    tx_req   = 1'b0;
    tx_valid = 1'b0;
    check({name, " finished"}, over, 1);
    check({name, " first_en"}, first_en, 2);
    check({name, " stream_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bits_bad++;
    check({name, " stream_bits"}, bits_bad, 0);
    check({name, " byte_clkd"}, bclk_bad, 0);
    check({name, " handshakes"}, hs, exp_hs);
    check({name, " done_pulses"}, done_cnt, 1);
    check({name, " done_on_last"}, done_at, en_cnt);
    if (got_q.size() > 0)
      check({name, " trail_level"}, got_q[got_q.size() - 1], exp_trail);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] w;
    int lock, bad, n, cyc, gap;
    rst      = 1'b1;
    tx_req   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    #1;
    check("reset_outs", {tx_ready, dtxhsp, hs_tx_en, hs_byte_clkd, burst_done}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", state_dbg, 0);
    check("reset_outs_idle", {tx_ready, dtxhsp, hs_tx_en, hs_byte_clkd, burst_done}, 0);

    vecs[0] = '{"one_byte",   1, 0, 24'h00005A, 1, 1'b1};
    vecs[1] = '{"three_byte", 3, 0, 24'h80FF01, 3, 1'b0};
    vecs[2] = '{"empty",      0, 1, 24'h000000, 0, 1'b0};
    vecs[3] = '{"backpress",  1, 2, 24'h0000C3, 1, 1'b0};
    for (int v = 0; v < 4; v++) begin
      for (int b = 0; b < 3; b++) payload[b] = vecs[v].bytes[8 * b +: 8];
      run_burst(vecs[v].name, vecs[v].n, vecs[v].mode, vecs[v].exp_hs, vecs[v].exp_trail);
    end

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      for (int b = 0; b < n; b++) payload[b] = 8'($urandom);
      run_burst($sformatf("rand%0d", r), n, 0, n, ~payload[n - 1][7]);
    end

    // loopback through a deserializer model: find SYNC, then slice bytes
    for (int b = 0; b < 64; b++) payload[b] = 8'($urandom);
    run_burst("loop64", 64, 0, 64, ~payload[63][7]);
    lock = -1;
    for (int i = 0; i + 8 <= got_q.size() && lock < 0; i++) begin
      for (int j = 0; j < 8; j++) w[j] = got_q[i + j];
      if (w == SW) lock = i;
    end
    check("loop_sync_pos", lock, ZC);
    bad = 0;
    for (int b = 0; b < 64; b++) begin
      if (lock < 0 || lock + 16 + 8 * b > got_q.size()) bad++;
      else begin
        for (int j = 0; j < 8; j++) w[j] = got_q[lock + 8 + 8 * b + j];
        if (w != payload[b]) bad++;
      end
    end
    check("loop_bytes", bad, 0);

    // request held across the end of a burst: exactly one quiet cycle, then a new burst
    tx_req = 1'b1;
    cyc = 0;
    while (!burst_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rereq_first_done", burst_done, 1);
    gap = 0;
    cyc = 0;
    @(negedge clk);
    while (!hs_tx_en && cyc < 20) begin
      gap++;
      cyc++;
      @(negedge clk);
    end
    check("rereq_gap", gap, 1);
    tx_req = 1'b0;
    cyc = 0;
    while (hs_tx_en && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rereq_second_ends", hs_tx_en, 0);
    repeat (3) @(negedge clk);

    // asynchronous reset in the middle of a data byte
    tx_req   = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    repeat (ZC + 12) @(negedge clk);
    check("midburst_en", hs_tx_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outs", {tx_ready, dtxhsp, hs_tx_en, hs_byte_clkd, burst_done}, 0);
    tx_req   = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_state", state_dbg, 0);
    check("post_rst_outs", {tx_ready, dtxhsp, hs_tx_en, hs_byte_clkd, burst_done}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
